// File: rtl/dmem_ctrl_if.sv
// Request/response bus between the load/store stage (master) and dmem_ctrl (slave).
interface dmem_ctrl_if #(
    parameter int ADDR_W = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Byte/half/word data memory with a wait-state counter and a single-outstanding handshake.
// Optional debug read port enabled by defining DMEM_DBG_PORT_EN.
module dmem_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
`ifdef DMEM_DBG_PORT_EN
    input  logic [$clog2(DEPTH)-1:0] dbg_addr,
    output logic [31:0]              dbg_rdata,
`endif
    dmem_ctrl_if.slave               bus
);
    localparam int         IW   = $clog2(DEPTH);
    localparam logic [3:0] WS_L = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic              we_q, uns_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              rsp_valid_q, rsp_err_q;
    logic [31:0]       rsp_rdata_q;

    logic [31:0] mem_q [DEPTH];

    logic [IW-1:0] idx;
    logic [31:0]   word_rd, wdata_sh, ld_c;
    logic [3:0]    be;
    logic [7:0]    ld_b;
    logic [15:0]   ld_h;
    logic          err_c, commit, mem_we;

    assign idx     = addr_q[IW+1:2];
    assign word_rd = mem_q[idx];
    // The commit edge is the last WAIT cycle; WAIT is always visited, so latency is 1+WAIT_STATES.
    assign commit  = (state_q == S_WAIT) && (cnt_q == 4'd0);
    assign mem_we  = commit && we_q && !err_c && rst_n;

    always_comb begin
        err_c = 1'b0;
        if (size_q == 2'b11)                               err_c = 1'b1;
        else if (size_q == 2'b01 && addr_q[0])             err_c = 1'b1;
        else if (size_q == 2'b10 && addr_q[1:0] != 2'b00)  err_c = 1'b1;
        else if ((addr_q >> (IW + 2)) != '0)               err_c = 1'b1;
    end

    always_comb begin
        be       = 4'b0000;
        wdata_sh = wdata_q;
        ld_b     = word_rd[8*addr_q[1:0] +: 8];
        ld_h     = addr_q[1] ? word_rd[31:16] : word_rd[15:0];
        ld_c     = word_rd;
        case (size_q)
            2'b00: begin
                be       = 4'b0001 << addr_q[1:0];
                wdata_sh = {4{wdata_q[7:0]}};
                ld_c     = uns_q ? {24'd0, ld_b} : {{24{ld_b[7]}}, ld_b};
            end
            2'b01: begin
                be       = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata_sh = {2{wdata_q[15:0]}};
                ld_c     = uns_q ? {16'd0, ld_h} : {{16{ld_h[15]}}, ld_h};
            end
            2'b10: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // Array has no reset: contents survive rst_n.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem_q[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            size_q      <= 2'b00;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        we_q    <= bus.req_we;
                        uns_q   <= bus.req_unsigned;
                        size_q  <= bus.req_size;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        cnt_q   <= WS_L;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= err_c;
                        rsp_rdata_q <= (!we_q && !err_c) ? ld_c : 32'd0;
                        state_q     <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

`ifdef DMEM_DBG_PORT_EN
    assign dbg_rdata = mem_q[dbg_addr];
`endif
endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench: one instance with no wait states, one with three, sharing clock and reset.
module tb_dmem_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_ctrl_if #(.ADDR_W(32)) bus0 ();
    dmem_ctrl_if #(.ADDR_W(32)) bus3 ();

    logic        sel = 1'b0;
    logic        d_valid = 1'b0, d_we = 1'b0, d_uns = 1'b0, d_rready = 1'b0;
    logic [1:0]  d_size = 2'b00;
    logic [31:0] d_addr = '0, d_wdata = '0;

    assign bus0.req_valid = d_valid & ~sel;
    assign bus3.req_valid = d_valid &  sel;
    assign bus0.rsp_ready = d_rready & ~sel;
    assign bus3.rsp_ready = d_rready &  sel;
    assign bus0.req_we = d_we;    assign bus3.req_we = d_we;
    assign bus0.req_size = d_size;  assign bus3.req_size = d_size;
    assign bus0.req_unsigned = d_uns; assign bus3.req_unsigned = d_uns;
    assign bus0.req_addr = d_addr;  assign bus3.req_addr = d_addr;
    assign bus0.req_wdata = d_wdata; assign bus3.req_wdata = d_wdata;

    logic        r_valid, r_ready, r_err;
    logic [31:0] r_rdata;
    assign r_valid = sel ? bus3.rsp_valid : bus0.rsp_valid;
    assign r_ready = sel ? bus3.req_ready : bus0.req_ready;
    assign r_err   = sel ? bus3.rsp_err   : bus0.rsp_err;
    assign r_rdata = sel ? bus3.rsp_rdata : bus0.rsp_rdata;

`ifdef DMEM_DBG_PORT_EN
    logic [4:0]  dbg_a0 = '0, dbg_a3 = '0;
    logic [31:0] dbg_d0, dbg_d3;
    dmem_ctrl #(.ADDR_W(32), .DEPTH(32), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .dbg_addr(dbg_a0), .dbg_rdata(dbg_d0), .bus(bus0));
    dmem_ctrl #(.ADDR_W(32), .DEPTH(32), .WAIT_STATES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .dbg_addr(dbg_a3), .dbg_rdata(dbg_d3), .bus(bus3));
`else
    dmem_ctrl #(.ADDR_W(32), .DEPTH(32), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0));
    dmem_ctrl #(.ADDR_W(32), .DEPTH(32), .WAIT_STATES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3));
`endif

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called just after a negedge; returns at the negedge following the accept edge.
    task automatic send(input logic s, input logic we, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd);
        int guard = 0;
        sel = s; d_we = we; d_size = sz; d_uns = u; d_addr = a; d_wdata = wd;
        while (!r_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        chk("req_ready_before_send", {31'd0, r_ready}, 32'd1);
        d_valid = 1'b1;
        @(negedge clk);
        d_valid = 1'b0;
        d_wdata = 32'h5555_AAAA;
    endtask

    task automatic await_rsp(output int lat, output logic [31:0] rd, output logic er);
        lat = 0;
        while (!r_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        rd = r_rdata;
        er = r_err;
    endtask

    task automatic release_rsp();
        d_rready = 1'b1;
        @(negedge clk);
        d_rready = 1'b0;
    endtask

    task automatic xact(input logic s, input logic we, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
        send(s, we, sz, u, a, wd);
        await_rsp(lat, rd, er);
        release_rsp();
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          seen;

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready0", {31'd0, bus0.req_ready}, 32'd1);
        chk("rst_rsp_valid0", {31'd0, bus0.rsp_valid}, 32'd0);
        chk("rst_rsp_err0",   {31'd0, bus0.rsp_err},   32'd0);
        chk("rst_rdata0",     bus0.rsp_rdata,          32'd0);
        chk("rst_req_ready3", {31'd0, bus3.req_ready}, 32'd1);

        // word store/load, no wait states
        xact(0, 1, 2'b10, 0, 32'h3C, 32'h1234_5678, rd, er, lat);
        chk("st_w_lat", lat, 1); chk("st_w_rdata", rd, 0); chk("st_w_err", {31'd0, er}, 0);
        chk("rdy_after_rsp", {31'd0, bus0.req_ready}, 1);
        xact(0, 0, 2'b10, 0, 32'h3C, 0, rd, er, lat);
        chk("ld_w_lat", lat, 1); chk("ld_w", rd, 32'h1234_5678); chk("ld_w_err", {31'd0, er}, 0);

        // sub-word
        xact(0, 1, 2'b00, 0, 32'h3D, 32'hFFFF_FF80, rd, er, lat);
        chk("st_b_err", {31'd0, er}, 0);
        xact(0, 0, 2'b10, 0, 32'h3C, 0, rd, er, lat);  chk("ld_w_after_b", rd, 32'h1234_8078);
        xact(0, 0, 2'b00, 0, 32'h3D, 0, rd, er, lat);  chk("ld_b_s", rd, 32'hFFFF_FF80);
        xact(0, 0, 2'b00, 1, 32'h3D, 0, rd, er, lat);  chk("ld_b_u", rd, 32'h0000_0080);
        xact(0, 0, 2'b00, 0, 32'h3C, 0, rd, er, lat);  chk("ld_b0_s", rd, 32'h0000_0078);
        xact(0, 0, 2'b01, 0, 32'h3E, 0, rd, er, lat);  chk("ld_h_hi_s", rd, 32'h0000_1234);
        xact(0, 0, 2'b01, 0, 32'h3C, 0, rd, er, lat);  chk("ld_h_lo_s", rd, 32'hFFFF_8078);
        xact(0, 0, 2'b01, 1, 32'h3C, 0, rd, er, lat);  chk("ld_h_lo_u", rd, 32'h0000_8078);
        xact(0, 1, 2'b01, 0, 32'h3E, 32'h0000_BEEF, rd, er, lat);
        xact(0, 0, 2'b10, 0, 32'h3C, 0, rd, er, lat);  chk("ld_w_after_h", rd, 32'hBEEF_8078);

        // errors
        xact(0, 1, 2'b10, 0, 32'h40, 32'h1122_3344, rd, er, lat);
        xact(0, 1, 2'b01, 0, 32'h41, 32'h0000_BEEF, rd, er, lat);
        chk("err_h_mis", {31'd0, er}, 1); chk("err_h_mis_rd", rd, 0);
        xact(0, 0, 2'b10, 0, 32'h40, 0, rd, er, lat);  chk("no_side_effect", rd, 32'h1122_3344);
        xact(0, 1, 2'b10, 0, 32'h42, 32'h0, rd, er, lat); chk("err_w_mis", {31'd0, er}, 1);
        xact(0, 0, 2'b10, 0, 32'h80, 0, rd, er, lat);  chk("err_range", {31'd0, er}, 1);
        chk("err_range_rd", rd, 0);
        xact(0, 0, 2'b10, 0, 32'h8000_0040, 0, rd, er, lat); chk("err_hi_bit", {31'd0, er}, 1);
        xact(0, 0, 2'b11, 0, 32'h40, 0, rd, er, lat);  chk("err_size", {31'd0, er}, 1);
        chk("err_size_rd", rd, 0);
        xact(0, 1, 2'b00, 0, 32'h43, 32'h0000_0099, rd, er, lat);
        chk("st_b_lane3_err", {31'd0, er}, 0);
        xact(0, 0, 2'b10, 0, 32'h40, 0, rd, er, lat);  chk("ld_after_b3", rd, 32'h9922_3344);
        xact(0, 1, 2'b10, 0, 32'h7C, 32'h0BAD_F00D, rd, er, lat);
        xact(0, 0, 2'b10, 0, 32'h7C, 0, rd, er, lat);
        chk("last_word", rd, 32'h0BAD_F00D); chk("last_word_err", {31'd0, er}, 0);

        // three wait states with back-pressure
        xact(1, 1, 2'b10, 0, 32'h00, 32'h0, rd, er, lat);  chk("ws3_st_lat", lat, 4);
        xact(1, 1, 2'b10, 0, 32'h04, 32'hA5A5_0F0F, rd, er, lat);
        send(1, 0, 2'b10, 0, 32'h04, 0);
        d_addr = 32'h0;  // changes while busy must be ignored
        await_rsp(lat, rd, er);
        chk("ws3_ld_lat", lat, 4); chk("ws3_ld", rd, 32'hA5A5_0F0F);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", {31'd0, bus3.rsp_valid}, 1);
            chk("bp_rdata", bus3.rsp_rdata, 32'hA5A5_0F0F);
            chk("bp_err",   {31'd0, bus3.rsp_err}, 0);
            chk("bp_ready", {31'd0, bus3.req_ready}, 0);
        end
        release_rsp();
        chk("bp_ready_after", {31'd0, bus3.req_ready}, 1);
        chk("bp_valid_after", {31'd0, bus3.rsp_valid}, 0);

        // reset while a store is waiting
        send(1, 1, 2'b10, 0, 32'h00, 32'hDEAD_BEEF);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus3.rsp_valid) seen++;
        end
        chk("rst_wait_no_rsp", seen, 0);
        chk("rst_wait_ready", {31'd0, bus3.req_ready}, 1);
        xact(1, 0, 2'b10, 0, 32'h00, 0, rd, er, lat);  chk("rst_wait_no_store", rd, 32'h0);
        xact(0, 0, 2'b10, 0, 32'h3C, 0, rd, er, lat);  chk("mem_kept_on_rst", rd, 32'hBEEF_8078);

`ifdef DMEM_DBG_PORT_EN
        xact(0, 1, 2'b10, 0, 32'h08, 32'hCAFE_F00D, rd, er, lat);
        dbg_a0 = 5'd2;
        #1;
        chk("dbg_rdata", dbg_d0, 32'hCAFE_F00D);
        dbg_a0 = 5'd15;
        #1;
        chk("dbg_rdata_w15", dbg_d0, 32'hBEEF_8078);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
